// File: rtl/cpu_pkg.sv
// cpu_pkg: shared run-control types and constants for the single-cycle core
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [1:0] ALIGN_MASK = 2'b00;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;
  function automatic logic is_aligned(input logic [XLEN-1:0] a);
    return a[1:0] == ALIGN_MASK;
  endfunction
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: saturating wait counter, o_tc high once LIMIT un-acked cycles have been counted
module fetch_wait_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en && !o_tc) r_count <= r_count + 1'b1;
  assign o_tc = r_count == WIDTH'(LIMIT);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, FETCH/HALT/FAULT run control, retire counting and fault detection
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_fetch_req,
  input  logic            i_fetch_ack,
  input  logic            i_en_branch,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_ebreak,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_current_pc,
  output logic            o_retire,
  output logic            o_halted,
  output logic            o_fault,
  output logic [XLEN-1:0] o_instret
);
  state_t r_state, w_next_state;
  logic [XLEN-1:0] r_pc, r_instret, w_next_pc, w_target;
  logic w_fetch, w_retire, w_tc;
  assign w_fetch = r_state == S_FETCH;
  assign w_retire = w_fetch & i_fetch_ack;
  assign w_target = r_pc + i_branch_target;
  // the timer reaches terminal count one cycle before the timeout edge
  fetch_wait_timer #(.WIDTH(8), .LIMIT(TIMEOUT_CYCLES - 1)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (!w_fetch || i_fetch_ack || w_tc),
    .i_en   (w_fetch && !i_fetch_ack),
    .o_tc   (w_tc)
  );
  always_comb begin
    w_next_state = r_state;
    w_next_pc = r_pc;
    unique case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH:
        if (i_fetch_ack) begin
          if (i_ebreak) w_next_state = S_HALT;
          else if (i_en_branch) begin
            if (is_aligned(w_target)) w_next_pc = w_target;
            else w_next_state = S_FAULT;
          end else w_next_pc = r_pc + PC_STEP;
        end else if (w_tc) w_next_state = S_FAULT;
      S_HALT:
        if (i_resume) begin
          w_next_state = S_FETCH;
          w_next_pc = r_pc + PC_STEP;
        end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc <= RESET_VECTOR;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc <= w_next_pc;
      r_instret <= r_instret + XLEN'(w_retire);
    end
  assign o_fetch_req = w_fetch;
  assign o_halted = r_state == S_HALT;
  assign o_fault = r_state == S_FAULT;
  assign o_retire = w_retire;
  assign o_current_pc = r_pc;
  assign o_instret = r_instret;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (retire monitor plus status checks)
module tb_pc_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;
  exp_t q[$];
  logic a_rst_n, a_ack, a_br, a_eb, a_res;
  logic [31:0] a_tgt;
  logic a_req, a_ret, a_halt, a_flt;
  logic [31:0] a_pc, a_ir;
  pc_sequencer #(.RESET_VECTOR(32'h0), .TIMEOUT_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .o_fetch_req(a_req), .i_fetch_ack(a_ack),
    .i_en_branch(a_br), .i_branch_target(a_tgt), .i_ebreak(a_eb), .i_resume(a_res),
    .o_current_pc(a_pc), .o_retire(a_ret), .o_halted(a_halt), .o_fault(a_flt), .o_instret(a_ir)
  );
  logic b_rst_n, b_ack, b_req, b_ret, b_halt, b_flt;
  logic [31:0] b_pc, b_ir;
  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .TIMEOUT_CYCLES(16)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .o_fetch_req(b_req), .i_fetch_ack(b_ack),
    .i_en_branch(1'b0), .i_branch_target(32'h0), .i_ebreak(1'b0), .i_resume(1'b0),
    .o_current_pc(b_pc), .o_retire(b_ret), .o_halted(b_halt), .o_fault(b_flt), .o_instret(b_ir)
  );
  always @(negedge clk)
    if (a_ret === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected pc=%h instret=%h required=no retire", a_pc, a_ir);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (a_pc !== e.pc || a_ir !== e.ir) begin
          bad++;
          $display("FAIL retire pc=%h instret=%h required pc=%h instret=%h", a_pc, a_ir, e.pc, e.ir);
        end
      end
    end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic retire(input logic [31:0] pc, input logic [31:0] ir);
    exp_t e;
    e.pc = pc;
    e.ir = ir;
    q.push_back(e);
    a_ack = 1;
    step();
  endtask
  task automatic reset_a();
    a_rst_n = 0;
    a_ack = 0; a_br = 0; a_eb = 0; a_res = 0; a_tgt = 0;
    step();
    a_rst_n = 1;
    step();
  endtask
  initial begin
    a_rst_n = 0; a_ack = 0; a_br = 0; a_eb = 0; a_res = 0; a_tgt = 0;
    b_rst_n = 0; b_ack = 0;
    step();
    chk("reset_pc", a_pc, 32'h0);
    chk("reset_instret", a_ir, 32'h0);
    chk("reset_flags", {28'h0, a_req, a_ret, a_halt, a_flt}, 32'h0);
    a_rst_n = 1;
    #3 chk("idle_req", {31'h0, a_req}, 32'h0);
    step();
    chk("fetch_req", {31'h0, a_req}, 32'h1);
    for (int i = 0; i < 4; i++) retire(32'(4 * i), 32'(i));
    chk("seq_pc", a_pc, 32'h10);
    chk("seq_instret", a_ir, 32'h4);
    a_br = 1; a_tgt = -32'sd8;
    retire(32'h10, 32'h4);
    a_br = 0;
    chk("branch_back_pc", a_pc, 32'h08);
    retire(32'h08, 32'h5);
    retire(32'h0C, 32'h6);
    a_br = 1; a_tgt = 32'd6;
    retire(32'h10, 32'h7);
    a_br = 0;
    chk("misalign_fault", {31'h0, a_flt}, 32'h1);
    chk("misalign_pc", a_pc, 32'h10);
    chk("misalign_instret", a_ir, 32'h8);
    step();
    chk("fault_sticky", {30'h0, a_flt, a_req}, 32'h2);
    reset_a();
    for (int i = 0; i < 8; i++) retire(32'(4 * i), 32'(i));
    a_eb = 1; a_br = 1; a_tgt = 32'd8;
    retire(32'h20, 32'h8);
    chk("ebreak_state", {29'h0, a_halt, a_req, a_flt}, 32'h4);
    chk("ebreak_pc", a_pc, 32'h20);
    step();
    chk("ack_in_halt", a_pc ^ {a_ir[27:0], 3'h0, a_halt}, 32'h20 ^ 32'h91);
    a_ack = 0; a_eb = 0; a_br = 0; a_res = 1;
    step();
    a_res = 0;
    chk("resume_pc", a_pc, 32'h24);
    chk("resume_req", {30'h0, a_halt, a_req}, 32'h1);
    a_res = 1;
    retire(32'h24, 32'h9);
    a_res = 0;
    chk("resume_in_fetch", a_pc, 32'h28);
    a_ack = 0;
    for (int i = 0; i < 3; i++) step();
    chk("wait3_nofault", {31'h0, a_flt}, 32'h0);
    retire(32'h28, 32'hA);
    chk("wait3_ack_pc", a_pc, 32'h2C);
    a_ack = 0;
    for (int i = 0; i < 3; i++) step();
    chk("timeout3_nofault", {31'h0, a_flt}, 32'h0);
    step();
    chk("timeout4_fault", {31'h0, a_flt}, 32'h1);
    chk("timeout_pc", a_pc, 32'h2C);
    a_ack = 1;
    step();
    chk("timeout_sticky", {31'h0, a_flt}, 32'h1);
    reset_a();
    retire(32'h0, 32'h0);
    retire(32'h4, 32'h1);
    #2 a_rst_n = 0;
    #1 chk("async_rst_pc", a_pc, 32'h0);
    chk("async_rst_instret", a_ir, 32'h0);
    a_ack = 0;
    step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    b_rst_n = 1;
    step();
    chk("wrap_start", b_pc, 32'hFFFF_FFF8);
    b_ack = 1;
    step();
    chk("wrap_pc1", b_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", b_pc, 32'h0);
    chk("wrap_instret", b_ir, 32'h2);
    b_ack = 0;
    for (int i = 0; i < 15; i++) step();
    chk("timeout15_nofault", {31'h0, b_flt}, 32'h0);
    step();
    chk("timeout16_fault", {31'h0, b_flt}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
